clock_step_controller: RTL

- Front-panel stage directly upstream of the p18240 processor top. Conditions the raw board pushbuttons and switches into a clean one-cycle CPU step enable and a CPU reset.
- Runs on the board clock, so the processor advances only on `cpu_step`. Supports three behaviours:
  - single-step from a key;
  - free-run at a divided rate;
  - a hardware PC breakpoint.

---
 rtl/clock_step_controller_if.sv | 25 ++
 rtl/clock_step_controller.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/clock_step_controller_if.sv
// Front-panel bundle between the board (keys, switches, CPU PC) and the
// step controller. The controller uses the slave side.
interface clock_step_controller_if;
    logic        key_step_n;
    logic        key_rst_n;
    logic        run_sw;
    logic        bp_en;
    logic [15:0] bp_addr;
    logic [15:0] pc;
    logic        cpu_step;
    logic        cpu_reset_L;
    logic [1:0]  mode;
    logic        halted;
    logic [15:0] step_count;

    modport master (
        output key_step_n, key_rst_n, run_sw, bp_en, bp_addr, pc,
        input  cpu_step, cpu_reset_L, mode, halted, step_count
    );

    modport slave (
        input  key_step_n, key_rst_n, run_sw, bp_en, bp_addr, pc,
        output cpu_step, cpu_reset_L, mode, halted, step_count
    );
endinterface

// File: rtl/clock_step_controller.sv
// Debounces the board keys and turns them into a one-cycle CPU step enable,
// a free-running divided step, a PC breakpoint and a registered CPU reset.
module clock_step_controller #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RUN_DIV         = 5000000,
    parameter int CNT_W           = 24
) (
    input  logic                    clock,
    input  logic                    reset,
    clock_step_controller_if.slave  ifc
);
    typedef enum logic [1:0] {
        ST_STEP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_BREAK = 2'b10
    } mode_e;

    localparam int KEY_STEP = 0;
    localparam int KEY_RST  = 1;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_DIV - 1);

    logic [1:0]       key_raw, key_s1, key_s2, key_db, key_db_q;
    logic [CNT_W-1:0] db_cnt [2];
    logic [CNT_W-1:0] presc;
    mode_e            state;
    logic             armed;
    logic             step_q, reset_l_q, halted_q;
    logic [15:0]      count_q;
    logic             press, rst_held, bp_hit, bp_clear, terminal;

    assign key_raw = {ifc.key_rst_n, ifc.key_step_n};

    // Keys are released (1) out of reset so no phantom press appears.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_s1   <= '1;
            key_s2   <= '1;
            key_db   <= '1;
            key_db_q <= '1;
            // NOTE: db_cnt is a two-entry register array, not RAM, so every
            // entry is reset to discard any partial debounce count.
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep the synchronizer stages
            // sampling the previous cycle's values, independent of order.
            key_s1   <= key_raw;
            key_s2   <= key_s1;
            key_db_q <= key_db;
            for (int i = 0; i < 2; i++) begin
                if (key_s2[i] == key_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    key_db[i] <= key_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press    = key_db_q[KEY_STEP] & ~key_db[KEY_STEP];
    assign rst_held = ~key_db[KEY_RST];
    assign bp_hit   = ifc.bp_en && armed && (ifc.pc == ifc.bp_addr);
    assign bp_clear = !ifc.bp_en || (ifc.pc != ifc.bp_addr);
    assign terminal = (presc == RUN_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_STEP;
            presc     <= '0;
            armed     <= 1'b1;
            step_q    <= 1'b0;
            reset_l_q <= 1'b0;
            halted_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            step_q    <= 1'b0;
            reset_l_q <= ~rst_held;
            if (rst_held) begin
                // A press still steps so the CPU can clock in its reset.
                state    <= ST_STEP;
                halted_q <= 1'b0;
                presc    <= '0;
                armed    <= 1'b1;
                count_q  <= '0;
                step_q   <= press;
            end else begin
                if (bp_clear) armed <= 1'b1;
                case (state)
                    ST_STEP: begin
                        if (press) begin
                            step_q  <= 1'b1;
                            count_q <= count_q + 16'd1;
                        end
                        if (ifc.run_sw) begin
                            state <= ST_RUN;
                            presc <= '0;
                        end
                    end
                    ST_RUN: begin
                        presc <= terminal ? '0 : presc + CNT_W'(1);
                        if (terminal && bp_hit) begin
                            state    <= ST_BREAK;
                            halted_q <= 1'b1;
                            armed    <= 1'b0;
                        end else begin
                            if (terminal) begin
                                step_q  <= 1'b1;
                                count_q <= count_q + 16'd1;
                            end
                            if (!ifc.run_sw) state <= ST_STEP;
                        end
                    end
                    ST_BREAK: begin
                        if (press) begin
                            step_q   <= 1'b1;
                            count_q  <= count_q + 16'd1;
                            halted_q <= 1'b0;
                            presc    <= '0;
                            state    <= ifc.run_sw ? ST_RUN : ST_STEP;
                        end else if (!ifc.run_sw) begin
                            halted_q <= 1'b0;
                            state    <= ST_STEP;
                        end
                    end
                    default: begin
                        state    <= ST_STEP;
                        halted_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ifc.cpu_step    = step_q;
    assign ifc.cpu_reset_L = reset_l_q;
    assign ifc.mode        = state;
    assign ifc.halted      = halted_q;
    assign ifc.step_count  = count_q;
endmodule
